// File: rtl/hilo_pkg.sv
// HI/LO result stage: shared types and constants.
// State encoding, result kinds, register selects, data width.
package hilo_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    localparam logic KIND_MUL = 1'b0;
    localparam logic KIND_DIV = 1'b1;
    localparam logic SEL_LO   = 1'b0;
    localparam logic SEL_HI   = 1'b1;

endpackage

// File: rtl/hilo_fwd_mux.sv
// HI/LO read-forwarding select: handshake > mt write > stored.
// Ports: rd_sel_i, hs_wr_i/res_*_i, mt_wr_i/mt_*_i, hi/lo_q_i -> fwd_o.
module hilo_fwd_mux
    import hilo_pkg::*;
(
    input  logic            rd_sel_i,
    input  logic            hs_wr_i,
    input  logic [XLEN-1:0] res_hi_i,
    input  logic [XLEN-1:0] res_lo_i,
    input  logic            mt_wr_i,
    input  logic            mt_sel_i,
    input  logic [XLEN-1:0] mt_data_i,
    input  logic [XLEN-1:0] hi_q_i,
    input  logic [XLEN-1:0] lo_q_i,
    output logic [XLEN-1:0] fwd_o
);

    always_comb begin
        fwd_o = (rd_sel_i == SEL_HI) ? hi_q_i : lo_q_i;
        if (mt_wr_i && (mt_sel_i == rd_sel_i)) begin
            fwd_o = mt_data_i;
        end
        if (hs_wr_i) begin
            fwd_o = (rd_sel_i == SEL_HI) ? res_hi_i : res_lo_i;
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register pair behind the mul/div units, one op outstanding.
// Ports: issue_*, res_*, mt_*, rd_* handshakes; hi/lo, dz_flag, err status.
module hilo_unit
    import hilo_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic            issue_kind,
    output logic            issue_ready,
    input  logic            res_valid,
    input  logic            res_kind,
    input  logic [XLEN-1:0] res_hi,
    input  logic [XLEN-1:0] res_lo,
    input  logic            res_dz,
    output logic            res_ready,
    input  logic            mt_en,
    input  logic            mt_sel,
    input  logic [XLEN-1:0] mt_data,
    input  logic            rd_req,
    input  logic            rd_sel,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_valid,
    output logic            stall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            dz_flag,
    input  logic            dz_clr,
    output logic            err
);

    state_e            state_q, state_d;
    logic              pend_kind_q, pend_kind_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              dz_q, dz_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic              pending;
    logic              hs;
    logic              dz_res;
    logic              hs_wr;
    logic              mt_wr;
    logic              rd_acc;
    logic [XLEN-1:0]   fwd;

    assign pending = (state_q == ST_PENDING);
    assign hs      = pending & res_valid;
    // A zero-divisor divide reports through dz_flag and leaves HI/LO alone.
    assign dz_res  = hs & (res_kind == KIND_DIV) & res_dz;
    assign hs_wr   = hs & ~dz_res;
    assign mt_wr   = ~pending & mt_en;
    assign stall   = rd_req & pending & ~hs;
    assign rd_acc  = rd_req & ~stall;

    hilo_fwd_mux u_fwd (
        .rd_sel_i  (rd_sel),
        .hs_wr_i   (hs_wr),
        .res_hi_i  (res_hi),
        .res_lo_i  (res_lo),
        .mt_wr_i   (mt_wr),
        .mt_sel_i  (mt_sel),
        .mt_data_i (mt_data),
        .hi_q_i    (hi_q),
        .lo_q_i    (lo_q),
        .fwd_o     (fwd)
    );

    always_comb begin
        state_d     = state_q;
        pend_kind_d = pend_kind_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        dz_d        = dz_q;
        err_d       = err_q;
        rd_valid_d  = rd_acc;
        rd_data_d   = rd_acc ? fwd : rd_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (issue_valid) begin
                    state_d     = ST_PENDING;
                    pend_kind_d = issue_kind;
                end
            end
            ST_PENDING: begin
                if (issue_valid || mt_en) begin
                    err_d = 1'b1;
                end
                if (hs) begin
                    state_d = ST_IDLE;
                    if (res_kind != pend_kind_q) begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase

        if (mt_wr) begin
            if (mt_sel == SEL_HI) hi_d = mt_data;
            else                  lo_d = mt_data;
        end
        if (hs_wr) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end

        // Setting wins over a same-cycle clear.
        if (dz_res)      dz_d = 1'b1;
        else if (dz_clr) dz_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pend_kind_q <= KIND_MUL;
            hi_q        <= '0;
            lo_q        <= '0;
            dz_q        <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_kind_q <= pend_kind_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            dz_q        <= dz_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign issue_ready = ~pending;
    assign res_ready   = pending;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign dz_flag     = dz_q;
    assign err         = err_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: directed plan plus randomized traffic
// checked each cycle against a behavioural model of the HI/LO stage.
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_kind, issue_ready;
    logic        res_valid, res_kind, res_dz, res_ready;
    logic [31:0] res_hi, res_lo;
    logic        mt_en, mt_sel;
    logic [31:0] mt_data;
    logic        rd_req, rd_sel, rd_valid, stall;
    logic [31:0] rd_data, hi, lo;
    logic        dz_flag, dz_clr, err;

    always #5 clk = ~clk;

    hilo_unit dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_kind  (issue_kind),
        .issue_ready (issue_ready),
        .res_valid   (res_valid),
        .res_kind    (res_kind),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .res_dz      (res_dz),
        .res_ready   (res_ready),
        .mt_en       (mt_en),
        .mt_sel      (mt_sel),
        .mt_data     (mt_data),
        .rd_req      (rd_req),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .stall       (stall),
        .hi          (hi),
        .lo          (lo),
        .dz_flag     (dz_flag),
        .dz_clr      (dz_clr),
        .err         (err)
    );

    int checks = 0;
    int errors = 0;

    // Model: an operation is either outstanding or not; registers
    // hold whatever the last accepted write put there.
    bit          m_pend;
    logic        m_kind;
    logic [31:0] m_hi, m_lo, m_rdd;
    bit          m_dz, m_err, m_rdv;
    bit          last_stall;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(output bit es);
        bit          hs;
        bit          dzset;
        logic [31:0] nhi, nlo;
        hs    = m_pend && res_valid;
        es    = rd_req && m_pend && !hs;
        dzset = 1'b0;
        if (reset) begin
            m_pend = 0; m_hi = 0; m_lo = 0; m_dz = 0;
            m_err = 0; m_rdv = 0; m_rdd = 0;
            return;
        end
        nhi = m_hi;
        nlo = m_lo;
        if (m_pend) begin
            if (issue_valid || mt_en) m_err = 1;
            if (hs) begin
                if (res_kind !== m_kind) m_err = 1;
                if (res_kind && res_dz) begin
                    dzset = 1'b1;
                end else begin
                    nhi = res_hi;
                    nlo = res_lo;
                end
                m_pend = 0;
            end
        end else begin
            if (mt_en) begin
                if (mt_sel) nhi = mt_data;
                else        nlo = mt_data;
            end
            if (issue_valid) begin
                m_pend = 1;
                m_kind = issue_kind;
            end
        end
        if (dzset)       m_dz = 1;
        else if (dz_clr) m_dz = 0;
        // A read returns what the register holds after this cycle.
        m_rdv = rd_req && !es;
        if (m_rdv) m_rdd = rd_sel ? nhi : nlo;
        m_hi = nhi;
        m_lo = nlo;
    endtask

    task automatic cyc();
        bit es;
        #1;
        model_step(es);
        if (!reset) begin
            chk("stall", {31'd0, stall}, {31'd0, es});
            last_stall = stall;
        end else begin
            last_stall = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("dz_flag", {31'd0, dz_flag}, {31'd0, m_dz});
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_rdv});
        chk("rd_data", rd_data, m_rdd);
        chk("issue_ready", {31'd0, issue_ready}, {31'd0, !m_pend});
        chk("res_ready", {31'd0, res_ready}, {31'd0, m_pend});
    endtask

    task automatic idle_in();
        issue_valid = 0; issue_kind = 0;
        res_valid = 0; res_kind = 0; res_dz = 0;
        res_hi = 0; res_lo = 0;
        mt_en = 0; mt_sel = 0; mt_data = 0;
        rd_req = 0; rd_sel = 0; dz_clr = 0;
    endtask

    initial begin
        int n;
        idle_in();
        reset = 1;
        m_kind = 0;
        cyc();
        cyc();
        reset = 0;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("rst_res_ready", {31'd0, res_ready}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);

        mt_en = 1; mt_sel = 1; mt_data = 32'hDEADBEEF;
        cyc();
        mt_sel = 0; mt_data = 32'h12345678;
        cyc();
        idle_in();
        rd_req = 1; rd_sel = 1;
        cyc();
        chk("mfhi_valid", {31'd0, rd_valid}, 32'd1);
        chk("mfhi_data", rd_data, 32'hDEADBEEF);
        rd_sel = 0;
        cyc();
        chk("mflo_data", rd_data, 32'h12345678);
        idle_in();
        cyc();
        chk("rd_pulse", {31'd0, rd_valid}, 32'd0);

        issue_valid = 1; issue_kind = 1;
        cyc();
        idle_in();
        chk("res_ready_after_issue", {31'd0, res_ready}, 32'd1);
        rd_req = 1; rd_sel = 0;
        n = 0;
        repeat (5) begin
            cyc();
            n += int'(last_stall);
        end
        chk("stall_cycles", n, 32'd5);
        res_valid = 1; res_kind = 1; res_hi = 32'h3; res_lo = 32'h7;
        cyc();
        chk("hs_no_stall", {31'd0, last_stall}, 32'd0);
        chk("div_fwd_data", rd_data, 32'h7);
        chk("div_hi", hi, 32'h3);
        idle_in();

        mt_en = 1; mt_sel = 1; mt_data = 32'h11;
        cyc();
        mt_sel = 0; mt_data = 32'h22;
        cyc();
        idle_in();
        issue_valid = 1; issue_kind = 1;
        cyc();
        idle_in();
        res_valid = 1; res_kind = 1; res_dz = 1;
        res_hi = 32'h99; res_lo = 32'h98;
        cyc();
        idle_in();
        chk("dz_hi_kept", hi, 32'h11);
        chk("dz_lo_kept", lo, 32'h22);
        chk("dz_set", {31'd0, dz_flag}, 32'd1);
        dz_clr = 1;
        cyc();
        idle_in();
        chk("dz_cleared", {31'd0, dz_flag}, 32'd0);

        mt_en = 1; mt_sel = 0; mt_data = 32'h5;
        rd_req = 1; rd_sel = 0;
        cyc();
        idle_in();
        chk("mt_fwd_data", rd_data, 32'h5);
        issue_valid = 1; issue_kind = 0;
        cyc();
        idle_in();
        mt_en = 1; mt_sel = 0; mt_data = 32'hAAAA;
        cyc();
        idle_in();
        chk("mt_pend_lo", lo, 32'h5);
        chk("mt_pend_err", {31'd0, err}, 32'd1);
        res_valid = 1; res_kind = 0; res_hi = 32'h1; res_lo = 32'h2;
        cyc();
        idle_in();

        reset = 1;
        cyc();
        reset = 0;
        issue_valid = 1; issue_kind = 0;
        cyc();
        idle_in();
        res_valid = 1; res_kind = 1; res_hi = 32'h44; res_lo = 32'h55;
        cyc();
        idle_in();
        chk("kind_err", {31'd0, err}, 32'd1);
        chk("kind_hi", hi, 32'h44);
        chk("kind_lo", lo, 32'h55);

        issue_valid = 1; issue_kind = 1;
        cyc();
        idle_in();
        reset = 1;
        cyc();
        reset = 0;
        chk("rstp_issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("rstp_hi", hi, 32'h0);
        chk("rstp_lo", lo, 32'h0);
        rd_req = 1;
        #1;
        chk("rstp_stall", {31'd0, stall}, 32'd0);
        cyc();
        idle_in();

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            if (!last_stall) begin
                rd_req = ($urandom_range(0, 2) == 0);
                rd_sel = 1'($urandom);
            end
            if (m_pend) issue_valid = ($urandom_range(0, 19) == 0);
            else        issue_valid = ($urandom_range(0, 3) == 0);
            issue_kind = 1'($urandom);
            res_valid  = ($urandom_range(0, 2) == 0);
            res_kind   = ($urandom_range(0, 9) == 0) ? ~m_kind : m_kind;
            res_hi     = $urandom;
            res_lo     = $urandom;
            res_dz     = ($urandom_range(0, 4) == 0);
            if (m_pend) mt_en = ($urandom_range(0, 19) == 0);
            else        mt_en = ($urandom_range(0, 3) == 0);
            mt_sel  = 1'($urandom);
            mt_data = $urandom;
            dz_clr  = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
